// File: rtl/apb_master_bridge.sv
// Purpose: APB initiator; queues valid/ready commands and runs each one as a SETUP+ACCESS transfer.
// Latency: a command accepted at edge E0 is in SETUP after E1 and in ACCESS after E2, and completes at E3.
//          Read data is visible after E3.
// Backpressure: cmd_ready = !full. A read waits in the queue while the response slot is occupied.
//               Commands behind it wait too, so order is strict.
// Ports: clk/rst (async, active-high); cmd_* command stream in; rsp_* read response out;
//        psel/penable/paddr/pwrite/pwdata/prdata APB master side.
module apb_master_bridge #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        psel,
    output logic        penable,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          empty;
    logic          rd_done;
    logic          slot_free;
    logic          issue_ok;
    state_t        state;
    state_t        state_nxt;

    // ---------------- command FIFO ----------------
    assign cmd_ready = (count != FULL_CNT);
    assign empty     = (count == '0);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- issue gate ----------------
    // A completing read fills the slot on this edge. The next read cannot
    // go straight from ACCESS to SETUP, so it passes through IDLE.
    assign rd_done   = (state == ACCESS) && !pwrite;
    assign slot_free = (!rsp_valid || rsp_ready) && !rd_done;
    assign issue_ok  = !empty && (head.write || slot_free);

    // ---------------- transfer FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (issue_ok) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (issue_ok) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign psel    = (state != IDLE);
    assign penable = (state == ACCESS);

    // Address/data are loaded only on pop, so they are stable through the
    // SETUP and ACCESS phases and hold their values in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else if (pop) begin
            paddr  <= head.addr;
            pwrite <= head.write;
            pwdata <= head.wdata;
        end
    end

    // ---------------- response slot ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (rd_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= prdata;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: self-checking bench for apb_master_bridge. It combines table vectors,
//          hand-written corner sequences and a negedge scoreboard.
// Latency: not applicable (bench).
// Backpressure: the bench drives rsp_ready and honours cmd_ready.
module tb_apb_master_bridge;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    apb_master_bridge #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: fixed word at 0x20, inverted address elsewhere.
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : ~a;
    endfunction

    always_comb prdata = slave_data(paddr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       exp_xfer[$];
    logic [31:0] exp_rsp[$];
    xfer_t       mon_x;
    logic [31:0] mon_r;

    // Inputs change only just after posedge, so values seen at negedge are
    // exactly what the next posedge acts on.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                mon_x.w = cmd_write;
                mon_x.a = cmd_addr;
                mon_x.d = cmd_wdata;
                exp_xfer.push_back(mon_x);
                if (!cmd_write) exp_rsp.push_back(slave_data(cmd_addr));
            end
            if (psel && penable) begin
                chk1("sb_xfer_expected", exp_xfer.size() != 0, 1'b1);
                if (exp_xfer.size() != 0) begin
                    mon_x = exp_xfer.pop_front();
                    chk("sb_paddr", paddr, mon_x.a);
                    chk1("sb_pwrite", pwrite, mon_x.w);
                    if (mon_x.w) chk("sb_pwdata", pwdata, mon_x.d);
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk1("sb_rsp_expected", exp_rsp.size() != 0, 1'b1);
                if (exp_rsp.size() != 0) begin
                    mon_r = exp_rsp.pop_front();
                    chk("sb_rsp_rdata", rsp_rdata, mon_r);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        int   n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        chk1("push_accepted", acc, 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_xfer.size() != 0 || exp_rsp.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("drain", (exp_xfer.size() == 0) && (exp_rsp.size() == 0), 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
    } vec_t;

    vec_t        vecs[4];
    logic        ps[10];
    logic        pe[10];
    logic [31:0] ad[10];
    logic        any;
    int          idx;
    int          n;
    logic        acc;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h0000_0100, 32'hAAAA_5555, 32'hFFFF_FEFF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_psel", psel, 1'b0);
        chk1("rst_penable", penable, 1'b0);
        chk1("rst_pwrite", pwrite, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        #1;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        // Isolated single transfers: exact phase timing.
        for (int i = 0; i < 4; i++) begin
            push_cmd(vecs[i].w, vecs[i].a, vecs[i].d);
            chk1($sformatf("v%0d_nofall_psel", i), psel, 1'b0);
            @(posedge clk); #1;
            chk1($sformatf("v%0d_setup_psel", i), psel, 1'b1);
            chk1($sformatf("v%0d_setup_penable", i), penable, 1'b0);
            chk($sformatf("v%0d_setup_paddr", i), paddr, vecs[i].a);
            chk1($sformatf("v%0d_setup_pwrite", i), pwrite, vecs[i].w);
            chk($sformatf("v%0d_setup_pwdata", i), pwdata, vecs[i].d);
            @(posedge clk); #1;
            chk1($sformatf("v%0d_access_psel", i), psel, 1'b1);
            chk1($sformatf("v%0d_access_penable", i), penable, 1'b1);
            chk($sformatf("v%0d_access_paddr", i), paddr, vecs[i].a);
            chk($sformatf("v%0d_access_pwdata", i), pwdata, vecs[i].d);
            @(posedge clk); #1;
            chk1($sformatf("v%0d_done_psel", i), psel, 1'b0);
            chk1($sformatf("v%0d_done_penable", i), penable, 1'b0);
            chk1($sformatf("v%0d_done_rsp_valid", i), rsp_valid, !vecs[i].w);
            chk($sformatf("v%0d_hold_paddr", i), paddr, vecs[i].a);
            if (!vecs[i].w) chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].rd);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            chk1($sformatf("v%0d_rsp_cleared", i), rsp_valid, 1'b0);
            rsp_ready = 1'b0;
        end

        // Four back-to-back writes: psel high for 8 cycles, penable toggling.
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 32'h1000 + 32'(c * 16);
                cmd_wdata = 32'hB0B0_0000 + 32'(c);
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            ps[c] = psel;
            pe[c] = penable;
            ad[c] = paddr;
        end
        for (int c = 1; c < 9; c++) begin
            chk1($sformatf("b2b_psel_%0d", c), ps[c], 1'b1);
            chk1($sformatf("b2b_penable_%0d", c), pe[c], (c % 2) == 0);
            chk($sformatf("b2b_paddr_%0d", c), ad[c], 32'h1000 + 32'(((c - 1) / 2) * 16));
        end
        chk1("b2b_end_psel", ps[9], 1'b0);
        wait_drain();

        // Read stall: the slot is held, so the second read and the writes
        // behind it fill the FIFO and wait.
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cmd_valid = 1'b1;
            cmd_write = (c >= 2);
            cmd_addr  = (c == 0) ? 32'h30 : (c == 1) ? 32'h34 : 32'h40 + 32'((c - 2) * 4);
            cmd_wdata = 32'h5500_0000 + 32'(c);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk1("stall_full", cmd_ready, 1'b0);
        chk1("stall_rsp_valid", rsp_valid, 1'b1);
        chk1("stall_idle", psel, 1'b0);
        any = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            any = any | psel;
        end
        chk1("stall_psel_never", any, 1'b0);
        chk1("stall_still_full", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk1("unstall_rsp_popped", rsp_valid, 1'b0);
        chk1("unstall_setup_psel", psel, 1'b1);
        chk1("unstall_setup_penable", penable, 1'b0);
        chk("unstall_paddr", paddr, 32'h34);
        chk1("unstall_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("rd2_rsp_valid", rsp_valid, 1'b1);
        chk("rd2_rsp_rdata", rsp_rdata, 32'hFFFF_FFCB);
        chk1("rd2_then_write_psel", psel, 1'b1);
        chk1("rd2_then_write_penable", penable, 1'b0);
        chk("rd2_then_write_paddr", paddr, 32'h40);
        wait_drain();

        // Alternating W/R/W stream with cmd_valid held: 20 transfers, wrap-around.
        rsp_ready = 1'b1;
        idx = 0;
        n   = 0;
        while (idx < 20 && n < 300) begin
            cmd_valid = 1'b1;
            cmd_write = (idx % 2) == 0;
            cmd_addr  = 32'h2000 + 32'(idx * 4);
            cmd_wdata = {16'hC0DE, 16'(idx)};
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            n++;
        end
        cmd_valid = 1'b0;
        chk("alt_accepted", 32'(idx), 32'd20);
        wait_drain();

        // Reset during the ACCESS of a read with two writes queued.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cmd_valid = 1'b1;
            cmd_write = (c != 0);
            cmd_addr  = 32'h60 + 32'(c * 4);
            cmd_wdata = 32'h7700_0000 + 32'(c);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk1("prerst_access", psel && penable, 1'b1);
        chk1("prerst_read", pwrite, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk1("midrst_psel", psel, 1'b0);
        chk1("midrst_penable", penable, 1'b0);
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk1("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_paddr", paddr, 32'h0);
        exp_xfer.delete();
        exp_rsp.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        any = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            any = any | psel | rsp_valid;
        end
        chk1("postrst_quiet", any, 1'b0);
        rsp_ready = 1'b1;
        push_cmd(1'b1, 32'h70, 32'hFACE_0070);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
